wb_regfile: RTL

- Write-back end of the MEM/WB interface.
- Consumes the MEM/WB pipeline-register outputs and selects the write-back value (ALU result, load data or PC+8).
- Commits that value into a 32x32 general-purpose register file.
- Serves the two ID-stage read ports with write-first bypass, and keeps a retired-write counter plus last-write trace for debug.

---
 rtl/wb_regfile_pkg.sv | 25 ++
 rtl/wb_regfile_mux.sv | 32 +++
 rtl/wb_regfile.sv | 103 ++++++++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_pkg
// Description : Write-back source encodings and reset constants shared by the
//               write-back stage and the forwarding logic.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_regfile_pkg;

    localparam logic [1:0]  WDS_ALU  = 2'b00;
    localparam logic [1:0]  WDS_MEM  = 2'b01;
    localparam logic [1:0]  WDS_PC8  = 2'b10;
    localparam logic [1:0]  WDS_NONE = 2'b11;

    localparam logic [31:0] INIT_32  = 32'h0000_0000;
    localparam logic [4:0]  INIT_5   = 5'd0;
    localparam logic [1:0]  INIT_2   = 2'b00;

    // Single point of truth for "does this MEM/WB slot retire a register write".
    function automatic logic wb_we(input logic [4:0] addr, input logic [1:0] src);
        return (addr != INIT_5) && (src != WDS_NONE);
    endfunction

endpackage : wb_regfile_pkg
`default_nettype wire

// File: rtl/wb_regfile_mux.sv
`default_nettype none
// ============================================================================
// Module      : wb_mux
// Description : Write-back source select and write-enable decode.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mux
    import wb_regfile_pkg::*;
(
    input  logic [31:0] dataMemIn,
    input  logic [31:0] ALUResIn,
    input  logic [31:0] PCplus8In,
    input  logic [1:0]  WriteDataSrcIn,
    input  logic [4:0]  WriteRegAddrIn,
    output logic [31:0] wdata,
    output logic        we
);

    always_comb begin
        wdata = INIT_32;
        case (WriteDataSrcIn)
            WDS_ALU: wdata = ALUResIn;
            WDS_MEM: wdata = dataMemIn;
            WDS_PC8: wdata = PCplus8In;
            default: wdata = INIT_32;
        endcase
    end

    assign we = wb_we(WriteRegAddrIn, WriteDataSrcIn);

endmodule : wb_mux
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : MEM/WB write-back, 32x32 register file with write-first
//               bypass on two read ports, plus retired-write trace/counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      dataMemIn,
    input  logic [31:0]      ALUResIn,
    input  logic [31:0]      PCplus8In,
    input  logic [1:0]       WriteDataSrcIn,
    input  logic [4:0]       WriteRegAddrIn,
    input  logic [4:0]       rdAddrA,
    input  logic [4:0]       rdAddrB,
    output logic [31:0]      rdDataA,
    output logic [31:0]      rdDataB,
    output logic             wbValid,
    output logic [4:0]       wbAddr,
    output logic [31:0]      wbData,
    output logic [CNT_W-1:0] wbCount
);

    logic [31:0]      w_wdata;
    logic             w_we;
    // Register 0 is hardwired, so storage starts at index 1.
    logic [31:0]      r_regs [NREG-1:1];
    logic             r_valid;
    logic [4:0]       r_addr;
    logic [31:0]      r_data;
    logic [CNT_W-1:0] r_count;

    wb_mux u_wb_mux (
        .dataMemIn      (dataMemIn),
        .ALUResIn       (ALUResIn),
        .PCplus8In      (PCplus8In),
        .WriteDataSrcIn (WriteDataSrcIn),
        .WriteRegAddrIn (WriteRegAddrIn),
        .wdata          (w_wdata),
        .we             (w_we)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                r_regs[i] <= INIT_32;
            end
        end else if (w_we) begin
            r_regs[WriteRegAddrIn] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= INIT_5;
            r_data  <= INIT_32;
            r_count <= '0;
        end else begin
            r_valid <= w_we;
            if (w_we) begin
                r_addr  <= WriteRegAddrIn;
                r_data  <= w_wdata;
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Write-first: a value retiring this cycle is visible to ID immediately.
    always_comb begin
        rdDataA = INIT_32;
        if (rdAddrA == INIT_5)
            rdDataA = INIT_32;
        else if (w_we && (rdAddrA == WriteRegAddrIn))
            rdDataA = w_wdata;
        else
            rdDataA = r_regs[rdAddrA];
    end

    always_comb begin
        rdDataB = INIT_32;
        if (rdAddrB == INIT_5)
            rdDataB = INIT_32;
        else if (w_we && (rdAddrB == WriteRegAddrIn))
            rdDataB = w_wdata;
        else
            rdDataB = r_regs[rdAddrB];
    end

    assign wbValid = r_valid;
    assign wbAddr  = r_addr;
    assign wbData  = r_data;
    assign wbCount = r_count;

endmodule : wb_regfile
`default_nettype wire
